// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// Provides the 640x480@60 and 800x600@60 porch/sync/active sets and a
// constant-foldable clog2 used to size the internal counters.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz nominal pixel rate)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz (40 MHz nominal pixel rate), positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  // Smallest width able to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus region decodes.
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0,
  parameter int CW     = clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_in_active,
  output logic          o_sync,
  output logic          o_last
);

  localparam int TOTAL          = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START     = ACTIVE + FP;
  localparam int SYNC_END       = ACTIVE + FP + SYNC;
  localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);
  localparam logic POL_C        = (POL != 0);

  logic [CW-1:0] count_q;
  logic          in_sync;

  // Advance on enable, wrapping exactly at TOTAL-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_en) begin
      count_q <= (count_q == LAST_C) ? '0 : count_q + 1'b1;
    end
  end

  // Compare in int so a sync end equal to 2^CW cannot alias to zero.
  always_comb begin
    in_sync     = (int'(count_q) >= SYNC_START) && (int'(count_q) < SYNC_END);
    o_in_active = (int'(count_q) < ACTIVE);
    o_sync      = in_sync ? POL_C : ~POL_C;
    o_last      = (count_q == LAST_C);
    o_count     = count_q;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates and
// frame-event pulses for any mode, advancing only on the pixel strobe.
// Optional macro VGA_TIMING_REG_OUT_EN registers every output (one i_clk
// of latency); without it all outputs decode the counters combinationally.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int FW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_blanking,
  output logic          o_active,
  output logic          o_screenend,
  output logic          o_animate,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [FW-1:0] o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = clog2(H_TOTAL);
  localparam int VCW     = clog2(V_TOTAL);
  localparam logic [VCW-1:0] V_LAST_ACTIVE = VCW'(V_ACTIVE - 1);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_active, h_sync, h_last;
  logic           v_active, v_sync, v_last;
  logic           v_en;
  logic [FW-1:0]  frame_q;

  logic           hs_d, vs_d, active_d, screenend_d, animate_d;
  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;

  assign v_en = i_pix_stb & h_last;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CW     (HCW)
  ) u_h_axis (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_pix_stb),
    .o_count     (h_cnt),
    .o_in_active (h_active),
    .o_sync      (h_sync),
    .o_last      (h_last)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CW     (VCW)
  ) u_v_axis (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (v_en),
    .o_count     (v_cnt),
    .o_in_active (v_active),
    .o_sync      (v_sync),
    .o_last      (v_last)
  );

  // Count completed frames; a reset mid-frame discards the partial frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_q <= '0;
    end else if (v_en && v_last) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  // Decode the counters; coordinates clamp to the last active value in blanking.
  always_comb begin
    hs_d        = h_sync;
    vs_d        = v_sync;
    active_d    = h_active & v_active;
    screenend_d = v_en & v_last;
    animate_d   = v_en & (v_cnt == V_LAST_ACTIVE);
    x_d         = h_active ? XW'(h_cnt) : XW'(H_ACTIVE - 1);
    y_d         = v_active ? YW'(v_cnt) : YW'(V_ACTIVE - 1);
  end

`ifdef VGA_TIMING_REG_OUT_EN
  localparam logic HS_IDLE = (H_POL == 0);
  localparam logic VS_IDLE = (V_POL == 0);

  // Register every output one i_clk behind the counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hs        <= HS_IDLE;
      o_vs        <= VS_IDLE;
      o_active    <= 1'b1;
      o_blanking  <= 1'b0;
      o_screenend <= 1'b0;
      o_animate   <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_frame     <= '0;
    end else begin
      o_hs        <= hs_d;
      o_vs        <= vs_d;
      o_active    <= active_d;
      o_blanking  <= ~active_d;
      o_screenend <= screenend_d;
      o_animate   <= animate_d;
      o_x         <= x_d;
      o_y         <= y_d;
      o_frame     <= frame_q;
    end
  end
`else
  // Drive outputs straight from the decode, zero latency.
  always_comb begin
    o_hs        = hs_d;
    o_vs        = vs_d;
    o_active    = active_d;
    o_blanking  = ~active_d;
    o_screenend = screenend_d;
    o_animate   = animate_d;
    o_x         = x_d;
    o_y         = y_d;
    o_frame     = frame_q;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 (line level), a tiny
// 14x11 positive-sync mode (full frames) and 800x600 positive-sync (line level).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk, rst, stb;
  int   checks, failures, clk_cnt;

  // default 640x480, negative syncs
  logic       a_hs, a_vs, a_blank, a_act, a_se, a_an;
  logic [9:0] a_x;
  logic [8:0] a_y;
  logic [7:0] a_fr;
  // tiny mode: H 8/2/3/1 (14), V 6/1/2/2 (11), positive syncs
  logic       b_hs, b_vs, b_blank, b_act, b_se, b_an;
  logic [2:0] b_x;
  logic [2:0] b_y;
  logic [3:0] b_fr;
  // 800x600, positive syncs
  logic       c_hs, c_vs, c_blank, c_act, c_se, c_an;
  logic [9:0] c_x;
  logic [9:0] c_y;
  logic [7:0] c_fr;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(a_hs), .o_vs(a_vs), .o_blanking(a_blank), .o_active(a_act),
    .o_screenend(a_se), .o_animate(a_an), .o_x(a_x), .o_y(a_y), .o_frame(a_fr)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1), .V_POL(1), .XW(3), .YW(3), .FW(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(b_hs), .o_vs(b_vs), .o_blanking(b_blank), .o_active(b_act),
    .o_screenend(b_se), .o_animate(b_an), .o_x(b_x), .o_y(b_y), .o_frame(b_fr)
  );

  vga_timing_gen #(
    .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP),
    .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
    .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP),
    .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
    .H_POL(1), .V_POL(1), .XW(10), .YW(10), .FW(8)
  ) dut_c (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(c_hs), .o_vs(c_vs), .o_blanking(c_blank), .o_active(c_act),
    .o_screenend(c_se), .o_animate(c_an), .o_x(c_x), .o_y(c_y), .o_frame(c_fr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One active edge; returns on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clk_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clk_cnt = 0;
  endtask

  // Advance (strobe held high) until outputs show raster position p.
  task automatic goto(input int p);
    int guard;
    guard = 0;
    while (clk_cnt < p + LAT && guard < 20000) begin
      step();
      guard++;
    end
    if (clk_cnt < p + LAT) chk("goto_bound", 32'(clk_cnt), 32'(p + LAT));
  endtask

  initial begin
    int hs_cnt, vs_cnt, se_cnt, an_cnt;
    int a_low, a_fall1, a_fall2, c_high, c_first, a_vs_low;
    logic a_prev;

    checks = 0; failures = 0; clk_cnt = 0;
    rst = 1'b1; stb = 1'b1;
    @(negedge clk);

    // ---- reset state and first frames of the tiny mode, strobe every clock
    do_reset();
    goto(0);
    chk("rst_b_active", b_act, 1);   chk("rst_b_blank", b_blank, 0);
    chk("rst_b_x", b_x, 0);          chk("rst_b_y", b_y, 0);
    chk("rst_b_hs", b_hs, 0);        chk("rst_b_vs", b_vs, 0);
    chk("rst_b_frame", b_fr, 0);     chk("rst_b_se", b_se, 0);
    chk("rst_b_an", b_an, 0);
    chk("rst_a_hs", a_hs, 1);        chk("rst_a_vs", a_vs, 1);
    chk("rst_a_active", a_act, 1);   chk("rst_a_x", a_x, 0);
    chk("rst_c_hs", c_hs, 0);        chk("rst_c_vs", c_vs, 0);
    goto(7);   chk("b_x_h7", b_x, 7);       chk("b_act_h7", b_act, 1);
    goto(8);   chk("b_x_h8", b_x, 7);       chk("b_blank_h8", b_blank, 1);
    goto(9);   chk("b_hs_h9", b_hs, 0);
    goto(10);  chk("b_hs_h10", b_hs, 1);
    goto(12);  chk("b_hs_h12", b_hs, 1);
    goto(13);  chk("b_hs_h13", b_hs, 0);    chk("b_x_h13", b_x, 7);
    goto(14);  chk("b_x_line1", b_x, 0);    chk("b_y_line1", b_y, 1);
               chk("b_act_line1", b_act, 1);
    goto(82);  chk("b_an_pre", b_an, 0);
    goto(83);  chk("b_an_hit", b_an, 1);    chk("b_y_v5", b_y, 5);
               chk("b_se_at_an", b_se, 0);
    goto(84);  chk("b_an_post", b_an, 0);   chk("b_y_v6", b_y, 5);
               chk("b_blank_v6", b_blank, 1); chk("b_x_v6", b_x, 0);
    goto(97);  chk("b_vs_v6", b_vs, 0);
    goto(98);  chk("b_vs_v7", b_vs, 1);
    goto(125); chk("b_vs_v8end", b_vs, 1);
    goto(126); chk("b_vs_v9", b_vs, 0);
    goto(152); chk("b_y_v10", b_y, 5);      chk("b_se_pre", b_se, 0);
    goto(153); chk("b_se_hit", b_se, 1);    chk("b_frame_pre", b_fr, 0);
    goto(154); chk("b_se_post", b_se, 0);   chk("b_frame_1", b_fr, 1);
               chk("b_y_wrap", b_y, 0);     chk("b_act_wrap", b_act, 1);

    hs_cnt = 0; vs_cnt = 0; se_cnt = 0; an_cnt = 0;
    for (int p = 154; p < 308; p++) begin
      goto(p);
      hs_cnt += int'(b_hs); vs_cnt += int'(b_vs);
      se_cnt += int'(b_se); an_cnt += int'(b_an);
    end
    chk("b_hs_clocks_frame", 32'(hs_cnt), 33);
    chk("b_vs_clocks_frame", 32'(vs_cnt), 28);
    chk("b_se_per_frame", 32'(se_cnt), 1);
    chk("b_an_per_frame", 32'(an_cnt), 1);
    goto(308); chk("b_frame_2", b_fr, 2);   chk("b_se_f2", b_se, 0);

    // ---- line timing of 640x480 and 800x600
    do_reset();
    a_low = 0; a_fall1 = -1; a_fall2 = -1; c_high = 0; c_first = -1; a_vs_low = 0;
    a_prev = 1'b1;
    for (int p = 0; p < 1600; p++) begin
      goto(p);
      if (!a_hs) a_low++;
      if (!a_vs) a_vs_low++;
      if (a_prev && !a_hs) begin
        if (a_fall1 < 0) a_fall1 = p; else if (a_fall2 < 0) a_fall2 = p;
      end
      a_prev = a_hs;
      if (c_hs) begin
        c_high++;
        if (c_first < 0) c_first = p;
      end
      if (p == 639) begin chk("a_x_639", a_x, 639); chk("a_act_639", a_act, 1); end
      if (p == 640) begin chk("a_x_640", a_x, 639); chk("a_blank_640", a_blank, 1); end
      if (p == 799) chk("a_x_799", a_x, 639);
      if (p == 800) begin
        chk("a_y_line1", a_y, 1); chk("a_x_line1", a_x, 0); chk("a_act_line1", a_act, 1);
      end
      if (p == 1055) begin
        chk("c_x_1055", c_x, 799); chk("c_blank_1055", c_blank, 1); chk("c_y_1055", c_y, 0);
      end
      if (p == 1056) begin chk("c_y_line1", c_y, 1); chk("c_x_line1", c_x, 0); end
    end
    chk("a_hs_low_clocks", 32'(a_low), 192);
    chk("a_hs_fall1", 32'(a_fall1), 656);
    chk("a_hs_fall2", 32'(a_fall2), 1456);
    chk("a_vs_low_clocks", 32'(a_vs_low), 0);
    chk("c_hs_high_clocks", 32'(c_high), 128);
    chk("c_hs_first", 32'(c_first), 840);

    // ---- reset mid-frame truncates the frame
    do_reset();
    goto(201);
    chk("b_frame_before_mid_rst", b_fr, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_b_frame", b_fr, 0);  chk("mid_rst_b_x", b_x, 0);
    chk("mid_rst_b_y", b_y, 0);       chk("mid_rst_b_act", b_act, 1);
    chk("mid_rst_b_hs", b_hs, 0);     chk("mid_rst_b_vs", b_vs, 0);
    chk("mid_rst_b_se", b_se, 0);     chk("mid_rst_a_hs", a_hs, 1);
    rst = 1'b0;
    clk_cnt = 0;
    se_cnt = 0;
    for (int p = 0; p < 153; p++) begin
      goto(p);
      se_cnt += int'(b_se);
    end
    chk("b_se_after_mid_rst", 32'(se_cnt), 0);
    goto(153); chk("b_se_full_frame", b_se, 1);

    // ---- strobe every 4th clock
    do_reset();
    se_cnt = 0; an_cnt = 0;
    for (int n = 0; n <= 616; n++) begin
      stb = (n % 4 == 0);
      #1;
      se_cnt += int'(b_se); an_cnt += int'(b_an);
      if (n == LAT + 2)   chk("stb4_x_hold2", b_x, 1);
      if (n == LAT + 4)   chk("stb4_x_hold4", b_x, 1);
      if (n == LAT + 5)   chk("stb4_x_adv", b_x, 2);
      if (n == LAT + 52)  chk("stb4_y_v0", b_y, 0);
      if (n == LAT + 53)  chk("stb4_y_v1", b_y, 1);
      if (n == LAT + 332) chk("stb4_an_hit", b_an, 1);
      if (n == LAT + 612) chk("stb4_se_hit", b_se, 1);
      if (n == LAT + 613) chk("stb4_se_post", b_se, 0);
      step();
    end
    chk("stb4_se_count", 32'(se_cnt), 1);
    chk("stb4_an_count", 32'(an_cnt), 1);
    chk("stb4_frame_1", b_fr, 1);
    stb = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
